// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Bit-serial adder/subtractor. One full-adder bit is evaluated per clock,
// LSB first, with the inter-bit carry held in a flip-flop. An operation is
// accepted when start=1 while idle. The result appears WIDTH cycles later,
// together with a one-cycle done pulse.
//
// Parameters
//   WIDTH     operand/result width in bits (2..32)
//
// Ports
//   clk       single clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     request a new operation (ignored while busy)
//   mode      0 = a+b+cin, 1 = a-b (cin ignored); sampled with start
//   a, b      operands; sampled with start
//   cin       carry-in for add; sampled with start
//   sum       result of the last completed operation
//   cout      carry out of MSB (subtract: 1 = no borrow)
//   overflow  two's-complement overflow of the last result
//   busy      operation in progress
//   done      one-cycle pulse when sum/cout/overflow update
// ---------------------------------------------------------------------------
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow,
   output logic             busy,
   output logic             done
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             carry;

   // Operand shift registers; bit 0 is always the bit being added.
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;

   // Result bits collected so far. Only WIDTH-1 bits are stored: on the
   // final bit the last sum bit is combined directly into the output load.
   logic [WIDTH-2:0] res;

   logic             bit_s;
   logic             bit_c;
   logic [WIDTH-1:0] res_nxt;

   function automatic logic fa_sum(input logic x, input logic y, input logic c);
      return x ^ y ^ c;
   endfunction

   function automatic logic fa_carry(input logic x, input logic y, input logic c);
      return (x & y) | (x & c) | (y & c);
   endfunction

   always_comb begin
      bit_s   = fa_sum(opa[0], opb[0], carry);
      bit_c   = fa_carry(opa[0], opb[0], carry);
      res_nxt = {bit_s, res};
   end

   // Control, carry and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         cnt      <= '0;
         carry    <= 1'b0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= RUN;
                  busy  <= 1'b1;
                  cnt   <= '0;
                  // Subtract is a + ~b + 1, so the carry seed supplies the +1.
                  carry <= mode ? 1'b1 : cin;
               end
            end
            RUN: begin
               carry <= bit_c;
               if (cnt == LAST_BIT) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  sum      <= res_nxt;
                  cout     <= bit_c;
                  // carry currently holds the carry into the MSB.
                  overflow <= carry ^ bit_c;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Operand and partial-result datapath; contents are meaningless while
   // idle, so these registers carry no reset.
   always_ff @(posedge clk) begin
      if (state == IDLE && start) begin
         opa <= a;
         opb <= mode ? ~b : b;
      end else if (state == RUN) begin
         opa <= opa >> 1;
         opb <= opb >> 1;
         res <= res_nxt[WIDTH-1:1];
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

   localparam int WIDTH = 8;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       mode;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic [7:0] sum;
   logic       cout;
   logic       overflow;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   serial_adder #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .mode     (mode),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .sum      (sum),
      .cout     (cout),
      .overflow (overflow),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       m;
      logic [7:0] va;
      logic [7:0] vb;
      logic       c;
      logic [7:0] es;
      logic       eco;
      logic       eov;
   } vec_t;

   vec_t vecs[9];

   // back-to-back operand table
   logic       bm [4];
   logic [7:0] ba [4];
   logic [7:0] bb [4];
   logic [7:0] bs [4];
   logic       bc [4];

   int         busy_cnt;
   int         done_cnt;
   int         dseen;
   int         t;
   int         prev;
   int         j;
   int         bad;
   logic [7:0] got;
   logic [9:0] held;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Called at a negedge; the following posedge is the accepting edge.
   task automatic launch(input logic m, input logic [7:0] va, input logic [7:0] vb, input logic c);
      start = 1'b1;
      mode  = m;
      a     = va;
      b     = vb;
      cin   = c;
      @(negedge clk);
      chk("busy_after_accept", 32'(busy), 1);
      start = 1'b0;
      a     = 8'($urandom);
      b     = 8'($urandom);
      cin   = 1'($urandom);
      mode  = 1'($urandom);
   endtask

   // Called at the negedge right after the accepting edge.
   task automatic finish_op(input logic [7:0] es, input logic eco, input logic eov, input string tag);
      int         n;
      int         hold_bad;
      logic [9:0] h;
      n        = 0;
      hold_bad = 0;
      h        = {sum, cout, overflow};
      while (!done && n < 3 * WIDTH) begin
         if ({sum, cout, overflow} !== h || busy !== 1'b1) hold_bad++;
         @(negedge clk);
         n++;
      end
      chk({tag, "_hold"},     32'(hold_bad), 0);
      chk({tag, "_latency"},  32'(n), WIDTH);
      chk({tag, "_sum"},      32'(sum), 32'(es));
      chk({tag, "_cout"},     32'(cout), 32'(eco));
      chk({tag, "_overflow"}, 32'(overflow), 32'(eov));
      chk({tag, "_busy_lo"},  32'(busy), 0);
      @(negedge clk);
      chk({tag, "_done_1cyc"}, 32'(done), 0);
      chk({tag, "_sum_held"},  32'(sum), 32'(es));
   endtask

   initial begin
      rst_n = 1'b1;
      start = 1'b0;
      mode  = 1'b0;
      a     = '0;
      b     = '0;
      cin   = 1'b0;

      //                m     a      b     cin   sum    cout  ovf
      vecs[0] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[1] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      vecs[2] = '{1'b0, 8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
      vecs[5] = '{1'b1, 8'h07, 8'h07, 1'b1, 8'h00, 1'b1, 1'b0};
      vecs[6] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      vecs[7] = '{1'b1, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1, 1'b0};
      vecs[8] = '{1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

      bm[0] = 1'b0; ba[0] = 8'h01; bb[0] = 8'h02; bs[0] = 8'h03; bc[0] = 1'b0;
      bm[1] = 1'b0; ba[1] = 8'h55; bb[1] = 8'hAA; bs[1] = 8'hFF; bc[1] = 1'b0;
      bm[2] = 1'b1; ba[2] = 8'h20; bb[2] = 8'h30; bs[2] = 8'hF0; bc[2] = 1'b0;
      bm[3] = 1'b1; ba[3] = 8'h30; bb[3] = 8'h20; bs[3] = 8'h10; bc[3] = 1'b1;

      // reset state
      #2 rst_n = 1'b0;
      #1;
      chk("rst_sum",  32'(sum), 0);
      chk("rst_cout", 32'(cout), 0);
      chk("rst_ovf",  32'(overflow), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_done", 32'(done), 0);

      // directed vector table
      for (int i = 0; i < 9; i++) begin
         launch(vecs[i].m, vecs[i].va, vecs[i].vb, vecs[i].c);
         finish_op(vecs[i].es, vecs[i].eco, vecs[i].eov, $sformatf("vec%0d", i));
      end

      // reset in the middle of an operation
      launch(1'b0, 8'h11, 8'h22, 1'b0);
      repeat (4) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_sum",  32'(sum), 0);
      chk("midrst_cout", 32'(cout), 0);
      chk("midrst_ovf",  32'(overflow), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_done", 32'(done), 0);
      dseen = 0;
      repeat (3) begin
         @(negedge clk);
         if (done) dseen++;
      end
      chk("midrst_no_done", 32'(dseen), 0);
      rst_n = 1'b1;
      launch(1'b0, 8'h03, 8'h04, 1'b0);
      finish_op(8'h07, 1'b0, 1'b0, "post_rst");

      // start pulses while busy are ignored
      launch(1'b0, 8'h12, 8'h34, 1'b0);
      busy_cnt = 0;
      done_cnt = 0;
      got      = '0;
      for (int n = 0; n < 20; n++) begin
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            got = sum;
         end
         start = (n == 1 || n == 4);
         if (start) begin
            a    = 8'hFF;
            b    = 8'hFF;
            mode = 1'b1;
         end
         @(negedge clk);
      end
      start = 1'b0;
      chk("ign_busy_cycles", 32'(busy_cnt), 8);
      chk("ign_done_count",  32'(done_cnt), 1);
      chk("ign_sum",         32'(got), 32'h46);

      // start held high: back-to-back operations
      start = 1'b1;
      mode  = bm[0];
      a     = ba[0];
      b     = bb[0];
      cin   = 1'b0;
      t     = 0;
      prev  = -1;
      j     = 0;
      bad   = 0;
      held  = '0;
      while (j < 4 && t < 80) begin
         @(negedge clk);
         t++;
         if (done) begin
            chk($sformatf("b2b%0d_sum", j),  32'(sum), 32'(bs[j]));
            chk($sformatf("b2b%0d_cout", j), 32'(cout), 32'(bc[j]));
            if (j > 0) chk($sformatf("b2b%0d_interval", j), 32'(t - prev), 9);
            prev = t;
            held = {sum, cout, overflow};
            j++;
            if (j < 4) begin
               mode = bm[j];
               a    = ba[j];
               b    = bb[j];
            end else begin
               start = 1'b0;
            end
         end else if (prev >= 0 && {sum, cout, overflow} !== held) begin
            bad++;
         end
      end
      start = 1'b0;
      chk("b2b_completions", 32'(j), 4);
      chk("b2b_stable",      32'(bad), 0);
      repeat (2) @(negedge clk);
      chk("b2b_idle_after", 32'(busy), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request a new operation; sampled only when busy=0.
REQ-005 SHALL have port mode  input  1  0 = add (a+b+cin), 1 = subtract (a-b, cin ignored); sampled with start.
REQ-006 SHALL have port a  input  WIDTH  operand A; sampled with start.
REQ-007 SHALL have port b  input  WIDTH  operand B; sampled with start.
REQ-008 SHALL have port cin  input  1  carry-in for add; sampled with start.
REQ-009 SHALL have port sum  output  WIDTH  registered result of last completed operation.
REQ-010 SHALL have port cout  output  1  carry out of MSB of last result (subtract: 1 = no borrow).
REQ-011 SHALL have port overflow  output  1  two's-complement overflow of last result.
REQ-012 SHALL have port busy  output  1  operation in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse when sum/cout/overflow update.

Function
REQ-014 SHALL be a bit-serial adder: one full-adder bit per clock, LSB first, carry held in a flip-flop between bits.
REQ-015 SHALL implement FSM states IDLE and RUN; IDLE->RUN on start=1 at an edge with busy=0; RUN->IDLE after WIDTH bit cycles.
REQ-016 On the accepting edge k SHALL latch a, b (inverted when mode=1), carry seed (cin when mode=0, 1 when mode=1), clear bit counter, set busy=1.
REQ-017 SHALL process bit i (i=0..WIDTH-1) at edge k+1+i, shifting operand registers right and the result bit into an internal shift register.
REQ-018 At edge k+WIDTH SHALL load sum, cout, overflow from the internal result, set done=1, set busy=0; latency from accepting edge to done = WIDTH cycles.
REQ-019 overflow SHALL equal (carry into MSB) XOR (carry out of MSB), using the inverted-b operand in subtract mode.
REQ-020 sum, cout, overflow SHALL hold their values from completion until the next completion; they SHALL NOT change during RUN.
REQ-021 done SHALL be high for exactly one cycle per completed operation and low otherwise.
REQ-022 start while busy=1 (including the accepting edge's following cycles up to edge k+WIDTH) SHALL be ignored; no queuing.
REQ-023 start=1 at edge k+WIDTH+1 (done high) SHALL be accepted, giving back-to-back operations every WIDTH+1 cycles; done drops at that edge.
REQ-024 Bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap within an operation.
REQ-025 Inputs a, b, cin, mode SHALL be don't-care except at the accepting edge.

Reset
REQ-026 rst_n=0 SHALL immediately (asynchronously) force state IDLE, sum=0, cout=0, overflow=0, busy=0, done=0, carry flip-flop=0, counter=0.
REQ-027 Reset asserted mid-RUN SHALL abort the operation with no done pulse and no output update; first start after rst_n rises SHALL be accepted normally.
REQ-028 Deassertion of rst_n SHALL take effect synchronously with the next clk edge; start sampled at that edge SHALL be accepted.

Verification (WIDTH=8)
REQ-029 add a=0xFF, b=0x01, cin=0 -> after 8 cycles done=1, sum=0x00, cout=1, overflow=0.
REQ-030 add a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, overflow=1; add a=0x10, b=0x20, cin=1 -> sum=0x31, cout=0, overflow=0.
REQ-031 subtract a=0x05, b=0x07 -> sum=0xFE, cout=0, overflow=0; subtract a=0x80, b=0x01 -> sum=0x7F, cout=1, overflow=1.
REQ-032 start pulsed at cycles 2 and 5 of a running operation -> exactly one done, result of first operands, busy stays high exactly 8 cycles.
REQ-033 rst_n low at bit 4 of an operation -> all outputs 0 immediately, no done; then start a=0x03, b=0x04 -> sum=0x07 after 8 cycles.
REQ-034 start held high continuously with new operands each acceptance -> done every 9 cycles, each sum correct, outputs stable between pulses.
